// File: rtl/vga_native_reg_bank.sv
// vga_native_reg_bank: native-side register bank behind the AXI-lite slave FSM.
// Holds shadowed VGA control/timing registers that are applied at frame start,
// sticky write-one-to-clear status, a free-running frame counter and the IRQ.
module vga_native_reg_bank #(
  parameter int          ADDR_WIDTH = 4,
  parameter int          DATA_WIDTH = 32,
  parameter int          H_ACT_RST  = 640,
  parameter int          V_ACT_RST  = 480,
  parameter logic [31:0] ID_VALUE   = 32'h5647_0001
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  write_en_i,
  input  logic [ADDR_WIDTH-1:0] addr_write_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  read_en_sync_i,
  input  logic [ADDR_WIDTH-1:0] addr_read_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  frame_start_i,
  input  logic                  frame_done_i,
  input  logic                  underflow_i,
  output logic                  ctrl_enable_o,
  output logic                  ctrl_pattern_o,
  output logic [11:0]           h_active_o,
  output logic [11:0]           v_active_o,
  output logic [23:0]           bg_color_o,
  output logic                  update_pending_o,
  output logic                  irq_o
);

  localparam logic [ADDR_WIDTH-1:0] IDX_CTRL   = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] IDX_HACT   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] IDX_VACT   = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] IDX_BG     = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] IDX_STATUS = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] IDX_FCNT   = ADDR_WIDTH'(5);
  localparam logic [ADDR_WIDTH-1:0] IDX_IRQEN  = ADDR_WIDTH'(6);
  localparam logic [ADDR_WIDTH-1:0] IDX_ID     = ADDR_WIDTH'(7);

  // Shadow copies (what software sees) and active copies (what the display uses)
  logic [1:0]            r_sh_ctrl;
  logic [11:0]           r_sh_h;
  logic [11:0]           r_sh_v;
  logic [23:0]           r_sh_bg;
  logic [1:0]            r_act_ctrl;
  logic [11:0]           r_act_h;
  logic [11:0]           r_act_v;
  logic [23:0]           r_act_bg;
  logic                  r_pending;
  logic                  r_apply_now;
  logic [1:0]            r_status;
  logic [1:0]            r_irq_en;
  logic [DATA_WIDTH-1:0] r_frame_cnt;
  logic                  r_irq;
  logic [DATA_WIDTH-1:0] r_data;

  logic                  w_wr_shadow;
  logic                  w_apply;
  logic [1:0]            w_status_clr;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_unused;

  // Upper write-data bits never land in any register field.
  assign w_unused = &{1'b0, data_i[DATA_WIDTH-1:24]};

  assign w_wr_shadow = write_en_i && (addr_write_i < ADDR_WIDTH'(4));
  // While the display is disabled nothing is scanning out, so a shadow write is
  // applied on the following edge instead of waiting for a frame start.
  assign w_apply     = (frame_start_i && r_pending) || r_apply_now;

  // Decode STATUS write-one-to-clear mask
  always_comb begin
    w_status_clr = 2'b00;
    if (write_en_i && (addr_write_i == IDX_STATUS)) begin
      w_status_clr = data_i[1:0];
    end else begin
      w_status_clr = 2'b00;
    end
  end

  // Read mux: returns shadow values for the shadowed registers
  always_comb begin
    w_rd_data = '0;
    case (addr_read_i)
      IDX_CTRL:   w_rd_data = DATA_WIDTH'(r_sh_ctrl);
      IDX_HACT:   w_rd_data = DATA_WIDTH'(r_sh_h);
      IDX_VACT:   w_rd_data = DATA_WIDTH'(r_sh_v);
      IDX_BG:     w_rd_data = DATA_WIDTH'(r_sh_bg);
      IDX_STATUS: w_rd_data = DATA_WIDTH'(r_status);
      IDX_FCNT:   w_rd_data = r_frame_cnt;
      IDX_IRQEN:  w_rd_data = DATA_WIDTH'(r_irq_en);
      IDX_ID:     w_rd_data = DATA_WIDTH'(ID_VALUE);
      default:    w_rd_data = '0;
    endcase
  end

  // Capture software writes into the shadow registers and IRQ enable
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sh_ctrl <= 2'b00;
      r_sh_h    <= 12'(H_ACT_RST);
      r_sh_v    <= 12'(V_ACT_RST);
      r_sh_bg   <= 24'h00_0000;
      r_irq_en  <= 2'b00;
    end else if (write_en_i) begin
      case (addr_write_i)
        IDX_CTRL:  r_sh_ctrl <= data_i[1:0];
        IDX_HACT:  r_sh_h    <= data_i[11:0];
        IDX_VACT:  r_sh_v    <= data_i[11:0];
        IDX_BG:    r_sh_bg   <= data_i[23:0];
        IDX_IRQEN: r_irq_en  <= data_i[1:0];
        default:   ;
      endcase
    end
  end

  // Copy all four shadows into the active set when an apply is due; a write in
  // the same cycle is not seen because the shadow only updates at this edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_act_ctrl <= 2'b00;
      r_act_h    <= 12'(H_ACT_RST);
      r_act_v    <= 12'(V_ACT_RST);
      r_act_bg   <= 24'h00_0000;
    end else if (w_apply) begin
      r_act_ctrl <= r_sh_ctrl;
      r_act_h    <= r_sh_h;
      r_act_v    <= r_sh_v;
      r_act_bg   <= r_sh_bg;
    end
  end

  // Track outstanding shadow updates: pending while running, immediate when idle
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pending   <= 1'b0;
      r_apply_now <= 1'b0;
    end else begin
      if (w_wr_shadow && r_act_ctrl[0]) begin
        r_pending <= 1'b1;
      end else if (w_apply) begin
        r_pending <= 1'b0;
      end
      r_apply_now <= w_wr_shadow && !r_act_ctrl[0];
    end
  end

  // Sticky status with W1C; a new event beats a simultaneous clear
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_status <= 2'b00;
    end else begin
      r_status <= (r_status & ~w_status_clr) | {underflow_i, frame_done_i};
    end
  end

  // Count frame starts, wrapping naturally at full scale
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_frame_cnt <= '0;
    end else if (frame_start_i) begin
      r_frame_cnt <= r_frame_cnt + DATA_WIDTH'(1);
    end
  end

  // Level interrupt from the currently registered status and enable
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_status & r_irq_en);
    end
  end

  // Register read data on the strobe and hold it until the next strobe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data <= '0;
    end else if (read_en_sync_i) begin
      r_data <= w_rd_data;
    end
  end

  assign data_o           = r_data;
  assign ctrl_enable_o    = r_act_ctrl[0];
  assign ctrl_pattern_o   = r_act_ctrl[1];
  assign h_active_o       = r_act_h;
  assign v_active_o       = r_act_v;
  assign bg_color_o       = r_act_bg;
  assign update_pending_o = r_pending;
  assign irq_o            = r_irq;

endmodule
